// File: rtl/iis_tx_sched_if.sv
// Bus bundle for the I2S transmit scheduler.
// Groups the sample-source handshake, the TX FIFO write port and the
// transmitter control/status pair so the scheduler and its environment
// connect through one port.
//   src_valid[1:0]     per-source sample valid
//   src_data[31:0]     {src1[15:0], src0[15:0]}
//   src_ready[1:0]     per-source ready
//   fifo_full          TX FIFO full
//   fifo_wr_en         TX FIFO write strobe
//   fifo_wr_data[15:0] TX FIFO write data
//   send_finish        transmitter burst-complete level
//   send_ctrl[2:0]     transmitter control {load, reserved, enable}
// The master modport is the scheduler; the slave modport is everything
// around it (sources, FIFO, transmitter).
interface iis_tx_sched_if;
    logic [1:0]  src_valid;
    logic [31:0] src_data;
    logic [1:0]  src_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        send_finish;
    logic [2:0]  send_ctrl;

    modport master (
        input  src_valid, src_data, fifo_full, send_finish,
        output src_ready, fifo_wr_en, fifo_wr_data, send_ctrl
    );

    modport slave (
        output src_valid, src_data, fifo_full, send_finish,
        input  src_ready, fifo_wr_en, fifo_wr_data, send_ctrl
    );
endinterface

// File: rtl/iis_tx_sched.sv
// Transmit scheduler for the I2S output path.
// Round-robin arbitrates two 16-bit sample sources, copies one burst of
// DATA_DEPTH samples from the winner into the TX FIFO, enables the
// transmitter once PREFILL samples are queued, and waits for send_finish
// (bounded by a TIMEOUT-cycle watchdog) before reporting completion.
// Ports:
//   clk_in            single clock
//   rst               synchronous active-high reset
//   start             begin one burst (accepted in IDLE only)
//   abort             cancel the current burst
//   bus               source/FIFO/transmitter bundle (master side)
//   busy              high whenever not IDLE
//   grant_id          source owning the current or last burst
//   done              one-cycle pulse at burst end
//   err               sticky DRAIN timeout flag, cleared by start
//   burst_cnt[15:0]   completed bursts (wrapping)
module iis_tx_sched #(
    parameter int DATA_DEPTH = 64,
    parameter int PREFILL    = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    iis_tx_sched_if.master bus,
    output logic           busy,
    output logic           grant_id,
    output logic           done,
    output logic           err,
    output logic [15:0]    burst_cnt
);

    localparam int CW = $clog2(DATA_DEPTH) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DATA_DEPTH);
    localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);
    localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_PREFILL,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          ptr;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] wr_cnt_inc;
    logic [WW-1:0] watchdog;
    logic          arb_any;
    logic          arb_gnt;
    logic          ready_g;
    logic          beat;
    logic          timeout_hit;
    logic          start_ok;

    // The pointer source wins when valid, otherwise the other source.
    assign arb_any     = |bus.src_valid;
    assign arb_gnt     = bus.src_valid[ptr] ? ptr : ~ptr;
    assign wr_cnt_inc  = wr_cnt + {{(CW-1){1'b0}}, beat};
    assign timeout_hit = (watchdog == TIMEOUT_C);
    assign start_ok    = (state == S_IDLE) && start && !abort;

    // Next-state logic. Fill thresholds look at the count including the
    // beat of this cycle so the state changes on the edge that writes the
    // threshold sample. Abort overrides everything outside IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (start)                          state_next = S_ARB;
            S_ARB:     if (arb_any)                        state_next = S_PREFILL;
            S_PREFILL: if (wr_cnt_inc >= PREFILL_C)        state_next = S_STREAM;
            S_STREAM:  if (wr_cnt_inc >= DEPTH_C)          state_next = S_DRAIN;
            S_DRAIN:   if (bus.send_finish || timeout_hit) state_next = S_DONE;
            S_DONE:                                        state_next = S_IDLE;
            default:                                       state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    // Combinational transfer path: only the granted source sees ready,
    // and nothing is accepted in a cycle that is being aborted or reset.
    always_comb begin
        ready_g          = 1'b0;
        beat             = 1'b0;
        bus.src_ready    = 2'b00;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = 16'h0000;
        if ((state == S_PREFILL || state == S_STREAM) && !abort && !rst) begin
            ready_g       = !bus.fifo_full && (wr_cnt < DEPTH_C);
            beat          = ready_g && bus.src_valid[grant_id];
            bus.src_ready = grant_id ? {ready_g, 1'b0} : {1'b0, ready_g};
            if (beat) begin
                bus.fifo_wr_en   = 1'b1;
                bus.fifo_wr_data = grant_id ? bus.src_data[31:16] : bus.src_data[15:0];
            end
        end
    end

    // State register plus the registered outputs, which are decoded from
    // the state being entered so they line up with it at the same edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state         <= S_IDLE;
            ptr           <= 1'b0;
            wr_cnt        <= '0;
            watchdog      <= '0;
            grant_id      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            burst_cnt     <= 16'h0000;
            bus.send_ctrl <= 3'b000;
        end else begin
            state         <= state_next;
            busy          <= (state_next != S_IDLE);
            done          <= (state_next == S_DONE);
            bus.send_ctrl <= (state_next == S_STREAM || state_next == S_DRAIN) ? 3'b101 : 3'b000;

            if (start_ok) begin
                wr_cnt <= '0;
            end else if (beat) begin
                wr_cnt <= wr_cnt_inc;
            end

            // Watchdog counts only while staying in DRAIN; it restarts
            // from zero on every DRAIN entry.
            if (state == S_DRAIN && state_next == S_DRAIN) begin
                watchdog <= watchdog + 1'b1;
            end else begin
                watchdog <= '0;
            end

            if (state == S_ARB && state_next == S_PREFILL) begin
                grant_id <= arb_gnt;
                ptr      <= ~arb_gnt;
            end

            // A send_finish in the same cycle as the timeout counts as a
            // normal completion.
            if (start_ok) begin
                err <= 1'b0;
            end else if (state == S_DRAIN && state_next == S_DONE && !bus.send_finish) begin
                err <= 1'b1;
            end

            if (state_next == S_DONE) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
        end
    end

endmodule
